// File: rtl/branch_resolver_if.sv
// Branch resolver bus: ID-stage branch info in, EX-stage outcome, flush/redirect and counters out.
interface branch_resolver_if #(
  parameter int unsigned COUNT_W = 32
);
  logic               ID_Branch_i;
  logic               ID_predict_i;
  logic [31:0]        ID_pc_i;
  logic [31:0]        ID_target_i;
  logic               Stall_i;
  logic               EX_Zero_i;
  logic               EX_Branch_o;
  logic               EX_gtTaken_o;
  logic               Flush_o;
  logic [31:0]        PC_Redirect_addr_o;
  logic [COUNT_W-1:0] Branch_cnt_o;
  logic [COUNT_W-1:0] Mispredict_cnt_o;

  // Pipeline side: drives ID/EX inputs, observes the resolution
  modport master (
    output ID_Branch_i, ID_predict_i, ID_pc_i, ID_target_i, Stall_i, EX_Zero_i,
    input  EX_Branch_o, EX_gtTaken_o, Flush_o, PC_Redirect_addr_o,
    input  Branch_cnt_o, Mispredict_cnt_o
  );

  // Resolver side
  modport slave (
    input  ID_Branch_i, ID_predict_i, ID_pc_i, ID_target_i, Stall_i, EX_Zero_i,
    output EX_Branch_o, EX_gtTaken_o, Flush_o, PC_Redirect_addr_o,
    output Branch_cnt_o, Mispredict_cnt_o
  );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: compares predicted vs. actual direction, flushes and
// redirects on mispredict, and keeps saturating branch/mispredict counters.
module branch_resolver #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  branch_resolver_if.slave    bus
);

  localparam int unsigned PC_W = 32;

  logic               ex_valid_q, ex_valid_d;
  logic               ex_pred_q, ex_pred_d;
  logic [PC_W-1:0]    ex_pc_q, ex_pc_d;
  logic [PC_W-1:0]    ex_target_q, ex_target_d;
  logic [COUNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [COUNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic               flush_c;

  // Resolve the branch sitting in EX against the live ALU comparison
  always_comb begin
    flush_c                = ex_valid_q & (ex_pred_q != bus.EX_Zero_i);
    bus.EX_Branch_o        = ex_valid_q;
    bus.EX_gtTaken_o       = ex_valid_q & bus.EX_Zero_i;
    bus.Flush_o            = flush_c;
    bus.PC_Redirect_addr_o = '0;
    if (flush_c) begin
      // predicted taken but fell through -> sequential PC; otherwise the target
      bus.PC_Redirect_addr_o = ex_pred_q ? (ex_pc_q + PC_W'(4)) : ex_target_q;
    end
    bus.Branch_cnt_o       = branch_cnt_q;
    bus.Mispredict_cnt_o   = mispred_cnt_q;
  end

  // Next-state: ID->EX transfer (only valid is gated) and saturating counters
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_pred_d     = bus.ID_predict_i;
    ex_pc_d       = bus.ID_pc_i;
    ex_target_d   = bus.ID_target_i;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (!flush_c && !bus.Stall_i) begin
      ex_valid_d = bus.ID_Branch_i;
    end

    if (ex_valid_q && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + COUNT_W'(1);
    end
    if (flush_c && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + COUNT_W'(1);
    end
  end

  // EX-stage and counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_q    <= 1'b0;
      ex_pred_q     <= 1'b0;
      ex_pc_q       <= '0;
      ex_target_q   <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pred_q     <= ex_pred_d;
      ex_pc_q       <= ex_pc_d;
      ex_target_q   <= ex_target_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expected EX results are queued when a branch
// is presented in ID and checked in the cycle it resolves.
module tb_branch_resolver;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  always #5 clk_i = ~clk_i;

  branch_resolver_if #(.COUNT_W(32)) bi ();
  branch_resolver_if #(.COUNT_W(4))  bi4 ();

  branch_resolver #(.COUNT_W(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bi.slave)
  );

  branch_resolver #(.COUNT_W(4)) dut4 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bi4.slave)
  );

  // Narrow-counter instance sees exactly the same stimulus
  assign bi4.ID_Branch_i  = bi.ID_Branch_i;
  assign bi4.ID_predict_i = bi.ID_predict_i;
  assign bi4.ID_pc_i      = bi.ID_pc_i;
  assign bi4.ID_target_i  = bi.ID_target_i;
  assign bi4.Stall_i      = bi.Stall_i;
  assign bi4.EX_Zero_i    = bi.EX_Zero_i;

  typedef struct packed {
    logic        vld;
    logic        pred;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] m_bcnt  = '0;
  logic [31:0] m_mcnt  = '0;
  logic [3:0]  m_bcnt4 = '0;
  logic [3:0]  m_mcnt4 = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_counters();
    check("branch_cnt",  64'(bi.Branch_cnt_o),      64'(m_bcnt));
    check("mispred_cnt", 64'(bi.Mispredict_cnt_o),  64'(m_mcnt));
    check("branch_cnt4", 64'(bi4.Branch_cnt_o),     64'(m_bcnt4));
    check("mispred_cnt4",64'(bi4.Mispredict_cnt_o), 64'(m_mcnt4));
  endtask

  // One clock cycle: present an ID instruction (with the outcome it will have in EX),
  // resolve whatever is in EX, optionally pulse reset while the EX result is showing.
  task automatic step(input logic br, input logic pred, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic outc, input logic stall,
                      input logic rst_mid);
    exp_t        e;
    logic        fl;
    logic [31:0] rd;
    @(negedge clk_i);
    if (sb.size() == 0) begin
      check("sb_empty", 64'(0), 64'(1));
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    bi.EX_Zero_i    = e.vld ? e.taken : 1'($urandom_range(0, 1));
    bi.ID_Branch_i  = br;
    bi.ID_predict_i = pred;
    bi.ID_pc_i      = pc;
    bi.ID_target_i  = tgt;
    bi.Stall_i      = stall;
    #1;
    fl = e.vld && (e.pred != e.taken);
    rd = fl ? (e.taken ? e.tgt : e.pc + 32'd4) : 32'd0;
    check("ex_branch", 64'(bi.EX_Branch_o),        64'(e.vld));
    check("gt_taken",  64'(bi.EX_gtTaken_o),       64'(e.vld & e.taken));
    check("flush",     64'(bi.Flush_o),            64'(fl));
    check("redirect",  64'(bi.PC_Redirect_addr_o), 64'(rd));
    check("flush4",    64'(bi4.Flush_o),           64'(fl));
    check_counters();

    if (rst_mid) begin
      rst_i = 1'b0;
      #1;
      m_bcnt = '0; m_mcnt = '0; m_bcnt4 = '0; m_mcnt4 = '0;
      check("rst_flush",     64'(bi.Flush_o),            64'(0));
      check("rst_ex_branch", 64'(bi.EX_Branch_o),        64'(0));
      check("rst_redirect",  64'(bi.PC_Redirect_addr_o), 64'(0));
      check("rst_flush4",    64'(bi4.Flush_o),           64'(0));
      check_counters();
      sb.delete();
      sb.push_back('0);
      bi.ID_Branch_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      return;
    end

    if (br && !stall && !fl) sb.push_back({1'b1, pred, outc, pc, tgt});
    else                     sb.push_back('0);

    if (e.vld) begin
      if (m_bcnt  != '1) m_bcnt  = m_bcnt  + 32'd1;
      if (m_bcnt4 != '1) m_bcnt4 = m_bcnt4 + 4'd1;
    end
    if (fl) begin
      if (m_mcnt  != '1) m_mcnt  = m_mcnt  + 32'd1;
      if (m_mcnt4 != '1) m_mcnt4 = m_mcnt4 + 4'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bi.ID_Branch_i  = 1'b1;
    bi.ID_predict_i = 1'b0;
    bi.ID_pc_i      = 32'h0000_0100;
    bi.ID_target_i  = 32'h0000_0140;
    bi.Stall_i      = 1'b0;
    bi.EX_Zero_i    = 1'b1;

    // Held in reset with a branch offered: everything must stay cleared
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ex_branch", 64'(bi.EX_Branch_o),        64'(0));
    check("reset_gt_taken",  64'(bi.EX_gtTaken_o),       64'(0));
    check("reset_flush",     64'(bi.Flush_o),            64'(0));
    check("reset_redirect",  64'(bi.PC_Redirect_addr_o), 64'(0));
    check_counters();
    @(negedge clk_i);
    bi.ID_Branch_i = 1'b0;
    rst_i = 1'b1;
    sb.push_back('0);

    idle(4);

    // Correctly predicted taken branch
    step(1'b1, 1'b1, 32'h100, 32'h140, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Predicted taken, not taken; the branch behind it is wrong-path
    step(1'b1, 1'b1, 32'h100, 32'h140, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h300, 32'h340, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Predicted not taken, taken: redirect to target
    step(1'b1, 1'b0, 32'h200, 32'h1F0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Stalled branch becomes a bubble, then resolves when re-presented
    step(1'b1, 1'b1, 32'h400, 32'h480, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h400, 32'h480, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Fall-through PC wraps to zero
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Back-to-back correct predictions
    step(1'b1, 1'b1, 32'h500, 32'h600, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h504, 32'h700, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h508, 32'h800, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Flush and stall together
    step(1'b1, 1'b0, 32'h900, 32'h980, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h904, 32'hA00, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Twenty mispredicts drive the 4-bit counters into saturation
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'(i & 1), 32'h1000 + 32'(i * 8), 32'h2000 + 32'(i * 8),
           1'(~i & 1), 1'b0, 1'b0);
      idle(1);
    end
    check("sat_bcnt4", 64'(bi4.Branch_cnt_o),     64'hF);
    check("sat_mcnt4", 64'(bi4.Mispredict_cnt_o), 64'hF);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
    end
    idle(1);

    // Reset pulse while a mispredict is showing
    step(1'b1, 1'b1, 32'hC00, 32'hC40, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b0, 32'hD00, 32'hD80, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

EX-stage resolution unit feeding the 2-bit branch predictor. Carries each predicted branch from ID into EX, compares the predicted direction with the ALU comparison result, and drives the outcome back to the predictor (`EX_Branch`/`EX_gtTaken`). On a mispredict it flushes the wrong-path instructions and supplies the recovery PC. Keeps saturating branch and mispredict counters for performance reporting.

## Interface
- `COUNT_W`, default 32: width of the performance counters.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `ID_Branch_i`  in  1  instruction in ID is a conditional branch (beq).
- `ID_predict_i`  in  1  direction predicted for that branch (predictor `predict_o`; 1 = taken).
- `ID_pc_i`  in  32  PC of the branch in ID.
- `ID_target_i`  in  32  branch target computed in ID (PC + (imm<<1)).
- `Stall_i`  in  1  load-use stall; the ID/EX stage receives a bubble this cycle.
- `EX_Zero_i`  in  1  ALU comparison result for the instruction in EX (1 = condition true, branch taken).
- `EX_Branch_o`  out  1  a valid branch is resolving in EX this cycle (to predictor `EX_Branch_i`).
- `EX_gtTaken_o`  out  1  resolving branch is actually taken (to predictor `EX_gtTaken_i`).
- `Flush_o`  out  1  mispredict; flush IF/ID and ID/EX at the next edge.
- `PC_Redirect_addr_o`  out  32  recovery PC; valid only while `Flush_o`=1, otherwise 0.
- `Branch_cnt_o`  out  COUNT_W  count of resolved branches.
- `Mispredict_cnt_o`  out  COUNT_W  count of mispredicted branches.

## Operation
- EX-stage registers: `ex_valid`, `ex_pred`, `ex_pc[31:0]`, `ex_target[31:0]`.
- Register update at each edge, in priority order:
  - if `Flush_o`=1: `ex_valid`<=0. The ID instruction is wrong-path.
  - else if `Stall_i`=1: `ex_valid`<=0 (bubble).
  - else: `ex_valid`<=`ID_Branch_i`; `ex_pred`, `ex_pc` and `ex_target` load from the ID inputs.
- The ID payload (`ex_pred`, `ex_pc`, `ex_target`) may load unconditionally. Only `ex_valid` is gated.
- Combinational EX outputs:
  - `EX_Branch_o` = `ex_valid`
  - `EX_gtTaken_o` = `ex_valid` & `EX_Zero_i`
  - `Flush_o` = `ex_valid` & (`ex_pred` != `EX_Zero_i`)
- Recovery PC while `Flush_o`=1:
  - predicted not-taken, actually taken: `ex_target`.
  - predicted taken, actually not-taken: `ex_pc` + 4, computed modulo 2^32 (0xFFFFFFFC + 4 = 0).
- Counters update at the edge:
  - `Branch_cnt_o` += 1 when `ex_valid`=1.
  - `Mispredict_cnt_o` += 1 when `Flush_o`=1.
  - Both saturate at all-ones and never wrap.
- Invariant: `Mispredict_cnt_o` ≤ `Branch_cnt_o` at all times.
- A correct prediction produces no flush and no redirect. IF already fetched the right path.

## Timing
- Reset (asynchronous, while `rst_i`=0): all registers and counters go to 0. Outputs are then `EX_Branch_o`=0, `EX_gtTaken_o`=0, `Flush_o`=0, `PC_Redirect_addr_o`=0, both counters 0.
- Reset asserted mid-operation clears a pending mispredict immediately (`Flush_o` falls combinationally with `ex_valid`).
- Latency:
  - A branch presented in ID at edge N resolves in EX during cycle N→N+1.
  - `Flush_o` and the redirect are valid in that same cycle.
  - The PC mux and pipeline flush take effect at edge N+1.
  - The predictor updates at edge N+1.
  - Counters reflect the branch after edge N+1.
- `Flush_o` is a single-cycle pulse per mispredicted branch. The cycle after a flush always has `ex_valid`=0.
- Flush and `Stall_i` in the same cycle: flush wins, result is a bubble.
- Back-to-back branches in ID with correct predictions resolve on consecutive cycles.

## Test plan
- Reset, then hold `ID_Branch_i`=0 → all outputs 0 indefinitely, counters stay 0.
- Branch pc=0x100, target=0x140, pred=1, next cycle `EX_Zero_i`=1 → `EX_Branch_o`=1, `EX_gtTaken_o`=1, `Flush_o`=0, `Branch_cnt_o` 0→1, `Mispredict_cnt_o` stays 0.
- Branch pc=0x100, target=0x140, pred=1, `EX_Zero_i`=0 → `Flush_o`=1 for one cycle, `PC_Redirect_addr_o`=0x104, `Mispredict_cnt_o`=1. A branch in ID during that cycle is dropped (`EX_Branch_o`=0 next cycle).
- Branch pc=0x200, target=0x1F0, pred=0, `EX_Zero_i`=1 → `Flush_o`=1, `PC_Redirect_addr_o`=0x1F0, `EX_gtTaken_o`=1.
- `Stall_i`=1 with a branch in ID → `EX_Branch_o`=0 next cycle. Re-presenting the branch with `Stall_i`=0 resolves it normally. Also check the pc=0xFFFFFFFC, pred=1, not-taken case → redirect 0x0.
- `COUNT_W`=4: 20 mispredicted branches → both counters hold 0xF. Async `rst_i` pulse mid-flush → `Flush_o` and both counters drop to 0 immediately.
